// File: rtl/sum_accumulator_pkg.sv
// Shared types and helpers for the sum_accumulator batch-summing stage.
package sum_accumulator_pkg;

   // Batch controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Width of the Count port: max(1, clog2(n)).
   function automatic int unsigned count_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Input-word and output-batch handshakes of sum_accumulator.
interface sum_accumulator_if
   import sum_accumulator_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 4,
   parameter int unsigned NUM_SAMPLES = 4,
   parameter int unsigned ACC_WIDTH   = 8
);
   localparam int unsigned CW = count_width(NUM_SAMPLES);

   logic                  In_Valid;
   logic                  In_Ready;
   logic [DATA_WIDTH-1:0] Sum;
   logic                  Carry;
   logic                  Out_Valid;
   logic                  Out_Ready;
   logic [ACC_WIDTH-1:0]  Acc_Out;
   logic                  Overflow;
   logic [CW-1:0]         Count;

   // Producer of words / consumer of batches.
   modport master (
      output In_Valid, Sum, Carry, Out_Ready,
      input  In_Ready, Out_Valid, Acc_Out, Overflow, Count
   );

   // The accumulator block itself.
   modport slave (
      input  In_Valid, Sum, Carry, Out_Ready,
      output In_Ready, Out_Valid, Acc_Out, Overflow, Count
   );

endinterface

// File: rtl/sum_accumulator_acc_adder.sv
// Combinational unsigned adder returning the sum and the carry out of WIDTH.
module acc_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   // Widen by one bit so the carry falls out of the top.
   always_comb begin
      {carry, sum} = {1'b0, a} + {1'b0, b};
   end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates NUM_SAMPLES {Carry, Sum} words per batch and presents the total
// with a wrap flag on an output handshake.
module sum_accumulator
   import sum_accumulator_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 4,
   parameter int unsigned NUM_SAMPLES = 4,
   parameter int unsigned ACC_WIDTH   = 8
) (
   input  logic              CLK,
   input  logic              RST_n,
   sum_accumulator_if.slave  bus
);

   localparam int unsigned CW = count_width(NUM_SAMPLES);

   state_t                state, state_nxt;
   logic [ACC_WIDTH-1:0]  acc_q;
   logic                  ovf_q;
   logic [CW-1:0]         cnt_q;
   logic [ACC_WIDTH-1:0]  word;
   logic [ACC_WIDTH-1:0]  add_sum;
   logic                  add_carry;
   logic                  in_ready;
   logic                  out_valid;
   logic                  accept;
   logic                  last_word;

   assign word      = ACC_WIDTH'({bus.Carry, bus.Sum});
   assign accept    = bus.In_Valid & in_ready;
   assign last_word = (cnt_q == CW'(NUM_SAMPLES - 1));

   acc_adder #(.WIDTH(ACC_WIDTH)) u_acc_adder (
      .a     (acc_q),
      .b     (word),
      .sum   (add_sum),
      .carry (add_carry)
   );

   // Next state and handshake outputs, decoded from state only.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.In_Valid) state_nxt = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (bus.In_Valid && last_word) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (bus.Out_Ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (!RST_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Accumulator, wrap flag and word counter; only loaded on an accepted word.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else if (accept) begin
         if (state == IDLE) begin
            acc_q <= word;
            ovf_q <= 1'b0;
            cnt_q <= CW'(1);
         end else begin
            acc_q <= add_sum;
            ovf_q <= ovf_q | add_carry;
            cnt_q <= last_word ? '0 : cnt_q + CW'(1);
         end
      end
   end

   assign bus.In_Ready  = in_ready;
   assign bus.Out_Valid = out_valid;
   assign bus.Acc_Out   = acc_q;
   assign bus.Overflow  = ovf_q;
   assign bus.Count     = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: an 8-bit and a 6-bit accumulator share the same
// stimulus and are checked against a batch-level arithmetic model.
module tb_sum_accumulator;

   localparam int unsigned DW = 4;
   localparam int unsigned NS = 4;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   // model: words of the open batch, last presented total, holding flag
   int   m_words[$];
   int   m_tot;
   bit   m_hold;
   bit   m_known;

   sum_accumulator_if #(.DATA_WIDTH(DW), .NUM_SAMPLES(NS), .ACC_WIDTH(8)) bus8 ();
   sum_accumulator_if #(.DATA_WIDTH(DW), .NUM_SAMPLES(NS), .ACC_WIDTH(6)) bus6 ();

   sum_accumulator #(.DATA_WIDTH(DW), .NUM_SAMPLES(NS), .ACC_WIDTH(8)) dut8 (
      .CLK(clk), .RST_n(rst_n), .bus(bus8)
   );
   sum_accumulator #(.DATA_WIDTH(DW), .NUM_SAMPLES(NS), .ACC_WIDTH(6)) dut6 (
      .CLK(clk), .RST_n(rst_n), .bus(bus6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("in_ready8",  32'(bus8.In_Ready),  32'(!m_hold));
      chk("out_valid8", 32'(bus8.Out_Valid), 32'(m_hold));
      chk("acc8",       32'(bus8.Acc_Out),   32'(m_tot % 256));
      chk("ovf8",       32'(bus8.Overflow),  32'(m_tot >= 256));
      chk("count8",     32'(bus8.Count),     32'(m_words.size()));
      chk("in_ready6",  32'(bus6.In_Ready),  32'(!m_hold));
      chk("out_valid6", 32'(bus6.Out_Valid), 32'(m_hold));
      chk("acc6",       32'(bus6.Acc_Out),   32'(m_tot % 64));
      chk("ovf6",       32'(bus6.Overflow),  32'(m_tot >= 64));
      chk("count6",     32'(bus6.Count),     32'(m_words.size()));
   endtask

   // One clock: drive inputs, confirm In_Ready ignores In_Valid, clock, check.
   task automatic step(input bit v, input int w, input bit ordy, input bit rn);
      bus8.In_Valid = v;  bus6.In_Valid = v;
      bus8.Sum = w[3:0];  bus6.Sum = w[3:0];
      bus8.Carry = w[4];  bus6.Carry = w[4];
      bus8.Out_Ready = ordy; bus6.Out_Ready = ordy;
      rst_n = rn;
      #1;
      if (m_known) begin
         chk("in_ready_comb8", 32'(bus8.In_Ready), 32'(!m_hold));
         chk("in_ready_comb6", 32'(bus6.In_Ready), 32'(!m_hold));
      end
      @(posedge clk);
      if (!rn) begin
         m_hold = 1'b0;
         m_words.delete();
         m_tot = 0;
         m_known = 1'b1;
      end else if (m_hold) begin
         if (ordy) m_hold = 1'b0;
      end else if (v) begin
         m_words.push_back(w);
         m_tot = m_words.sum();
         if (m_words.size() == NS) begin
            m_hold = 1'b1;
            m_words.delete();
         end
      end
      #1;
      if (m_known) check_all();
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      m_tot = 0;
      m_hold = 1'b0;
      m_known = 1'b0;
      rst_n = 1'b0;
      #2;

      // reset for two edges with In_Valid high
      step(1'b1, 9, 1'b0, 1'b0);
      step(1'b1, 9, 1'b0, 1'b0);

      // nominal batch 7,10,7,10
      step(1'b1, 7, 1'b0, 1'b1);
      step(1'b1, 10, 1'b0, 1'b1);
      step(1'b1, 7, 1'b0, 1'b1);
      step(1'b1, 10, 1'b0, 1'b1);
      chk("nominal_acc", 32'(bus8.Acc_Out), 32'd34);
      chk("nominal_valid", 32'(bus8.Out_Valid), 32'd1);

      // backpressure: words offered while holding are ignored
      for (int i = 0; i < 5; i++) step(1'b1, 3, 1'b0, 1'b1);
      chk("held_acc", 32'(bus8.Acc_Out), 32'd34);
      step(1'b0, 0, 1'b1, 1'b1);
      step(1'b1, 3, 1'b0, 1'b1);
      chk("fresh_acc", 32'(bus8.Acc_Out), 32'd3);
      step(1'b1, 3, 1'b0, 1'b1);
      step(1'b1, 3, 1'b0, 1'b1);
      step(1'b1, 3, 1'b0, 1'b1);
      step(1'b0, 0, 1'b1, 1'b1);

      // overflow: four words of 31
      for (int i = 0; i < 4; i++) step(1'b1, 31, 1'b0, 1'b1);
      chk("ovf_acc6", 32'(bus6.Acc_Out), 32'd60);
      chk("ovf_flag6", 32'(bus6.Overflow), 32'd1);
      chk("ovf_flag8", 32'(bus8.Overflow), 32'd0);
      step(1'b0, 0, 1'b1, 1'b1);

      // bubbles between words 1,2,3,4
      step(1'b1, 1, 1'b0, 1'b1);
      step(1'b1, 2, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b1, 3, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1);
      step(1'b1, 4, 1'b0, 1'b1);
      chk("bubble_acc", 32'(bus8.Acc_Out), 32'd10);
      step(1'b0, 0, 1'b1, 1'b1);

      // reset in the middle of a batch
      step(1'b1, 9, 1'b0, 1'b1);
      step(1'b1, 9, 1'b0, 1'b1);
      step(1'b1, 9, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 5, 1'b0, 1'b1);
      chk("midreset_acc", 32'(bus8.Acc_Out), 32'd20);
      step(1'b1, 7, 1'b0, 1'b0);

      // randomized traffic, rare resets
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 7, int'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), $urandom_range(0, 49) != 0);
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
